// File: rtl/gpio_mulpop_unit.sv
// Bus-mapped multiply/popcount peripheral with gpio capture and a completion counter.
// The multiplier is a sequential shift-add engine taking AW clocks per operation.
module gpio_mulpop_unit #(
  parameter int          AW   = 24,
  parameter int          RW   = 32,
  parameter logic [15:0] BASE = 16'h0380
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_in_s_insp,
  output logic [31:0] gpio_out
);

  localparam int AW2 = 2 * AW;
  localparam int IW  = (AW > 1) ? $clog2(AW) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_MULT, S_COUNT, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic           srd_p_q, srd_p_d;
  logic           swr_p_q, swr_p_d;
  logic           lat_p_q, lat_p_d;
  logic [AW-1:0]  a1_q, a1_d, a2_q, a2_d;
  logic [AW2-1:0] a1s_q, a1s_d;
  logic [AW-1:0]  a2s_q, a2s_d;
  logic [AW2-1:0] acc_q, acc_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [RW-1:0]  w_q, w_d;
  logic [5:0]     l_q, l_d;
  logic           valid_q, valid_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [31:0]    gpin_q, gpin_d;
  logic [31:0]    rdata_q, rdata_d;

  logic        rd_rise, wr_rise, lat_rise;
  logic        sel_a1, sel_a2, sel_w, sel_l, sel_st, sel_gp;
  logic        busy, ready;
  logic [63:0] acc64;
  logic [5:0]  pop;
  logic [31:0] rd_word;
  logic        unused_sdata;

  assign unused_sdata = ^sdata_in;

  assign rd_rise  = srd & ~srd_p_q;
  assign wr_rise  = swr & ~swr_p_q;
  assign lat_rise = gpio_latch & ~lat_p_q;

  assign sel_a1 = (saddress == BASE);
  assign sel_a2 = (saddress == BASE + 16'h08);
  assign sel_w  = (saddress == BASE + 16'h10);
  assign sel_l  = (saddress == BASE + 16'h18);
  assign sel_st = (saddress == BASE + 16'h20);
  assign sel_gp = (saddress == BASE + 16'h28);

  assign acc64 = 64'(acc_q);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      srd_p_q <= 1'b0;
      swr_p_q <= 1'b0;
      lat_p_q <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      a1s_q   <= '0;
      a2s_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      w_q     <= '0;
      l_q     <= '0;
      valid_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      gpin_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      srd_p_q <= srd_p_d;
      swr_p_q <= swr_p_d;
      lat_p_q <= lat_p_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      a1s_q   <= a1s_d;
      a2s_q   <= a2s_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
      l_q     <= l_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      gpin_q  <= gpin_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < RW; k++) begin
      pop = pop + 6'(acc64[k]);
    end
  end

  always_comb begin
    state_d = state_q;
    srd_p_d = srd;
    swr_p_d = swr;
    lat_p_d = gpio_latch;
    a1_d    = a1_q;
    a2_d    = a2_q;
    a1s_d   = a1s_q;
    a2s_d   = a2s_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    w_d     = w_q;
    l_d     = l_q;
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    gpin_d  = gpin_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_MULT: begin
        if (a2s_q[0]) acc_d = acc_q + a1s_q;
        a1s_d = a1s_q << 1;
        a2s_d = a2s_q >> 1;
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(AW - 1)) state_d = S_COUNT;
      end
      S_COUNT: begin
        w_d     = acc64[RW-1:0];
        l_d     = pop;
        valid_d = ((acc64 >> RW) == 64'd0);
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        cnt_d   = cnt_q + 32'd1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (wr_rise) begin
      unique case (1'b1)
        sel_a1: a1_d = sdata_in[AW-1:0];
        sel_a2: a2_d = sdata_in[AW-1:0];
        sel_st: begin
          if (state_q == S_IDLE) begin
            a1s_d   = AW2'(a1_q);
            a2s_d   = a2_q;
            acc_d   = '0;
            idx_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = S_MULT;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (rd_rise) rdata_d = rd_word;
    if (lat_rise) gpin_d = gpio_in;
  end

  always_comb begin
    busy  = (state_q != S_IDLE);
    ready = ~busy;
    unique case (1'b1)
      sel_a1:  rd_word = 32'(a1_q);
      sel_a2:  rd_word = 32'(a2_q);
      sel_w:   rd_word = done_q ? 32'(w_q) : 32'd0;
      sel_l:   rd_word = done_q ? 32'(l_q) : 32'd0;
      sel_st:  rd_word = {27'd0, err_q, done_q, busy, ready, valid_q};
      sel_gp:  rd_word = gpin_q;
      default: rd_word = 32'd0;
    endcase
  end

  assign sdata_out      = rdata_q;
  assign gpio_in_s_insp = gpin_q;
  assign gpio_out       = cnt_q;

endmodule

// File: tb/tb_gpio_mulpop_unit.sv
// Randomised bench for gpio_mulpop_unit against a product/popcount model.
// A second instance with AW=8, RW=16 shares the bus for the small-width case.
module tb_gpio_mulpop_unit;

  localparam logic [15:0] BASE = 16'h0380;
  localparam logic [15:0] A_A1 = BASE;
  localparam logic [15:0] A_A2 = BASE + 16'h08;
  localparam logic [15:0] A_W  = BASE + 16'h10;
  localparam logic [15:0] A_L  = BASE + 16'h18;
  localparam logic [15:0] A_ST = BASE + 16'h20;
  localparam logic [15:0] A_GP = BASE + 16'h28;
  localparam logic [15:0] A_NX = BASE + 16'h30;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] saddress = '0;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [31:0] sdata_in = '0;
  logic [31:0] gpio_in = '0;
  logic        gpio_latch = 1'b0;
  logic [31:0] sdata_out, gpio_in_s_insp, gpio_out;
  logic [31:0] sdata_out8, insp8, gout8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  // behavioural model of the AW=24 instance
  logic [23:0] m_a1, m_a2, s_a1, s_a2;
  logic [31:0] m_w;
  logic [31:0] m_l;
  logic [31:0] m_cnt;
  logic        m_valid, m_err, m_done, m_busy;
  logic [31:0] rd, rd8;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gpio_mulpop_unit #(.AW(24), .RW(32), .BASE(BASE)) u_dut (
    .clk(clk), .n_reset(n_reset), .saddress(saddress),
    .srd(srd), .swr(swr), .sdata_in(sdata_in),
    .sdata_out(sdata_out), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_in_s_insp(gpio_in_s_insp),
    .gpio_out(gpio_out)
  );

  gpio_mulpop_unit #(.AW(8), .RW(16), .BASE(BASE)) u_dut8 (
    .clk(clk), .n_reset(n_reset), .saddress(saddress),
    .srd(srd), .swr(swr), .sdata_in(sdata_in),
    .sdata_out(sdata_out8), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_in_s_insp(insp8),
    .gpio_out(gout8)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {27'd0, m_err, m_done, m_busy, ~m_busy, m_valid};
  endfunction

  function automatic logic [31:0] m_rd_w();
    return m_done ? m_w : 32'd0;
  endfunction

  function automatic logic [31:0] m_rd_l();
    return m_done ? m_l : 32'd0;
  endfunction

  task automatic model_reset();
    m_a1 = '0; m_a2 = '0; s_a1 = '0; s_a2 = '0;
    m_w = '0; m_l = '0; m_cnt = '0;
    m_valid = 1'b1; m_err = 1'b0; m_done = 1'b0; m_busy = 1'b0;
  endtask

  // all bus tasks begin and end just after a falling edge
  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    saddress = a; sdata_in = d; swr = 1'b1;
    @(posedge clk); @(negedge clk);
    swr = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    saddress = a; srd = 1'b1;
    @(posedge clk); @(negedge clk);
    d = sdata_out; rd8 = sdata_out8; srd = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wr_ops(input logic [23:0] a1, input logic [23:0] a2);
    bus_wr(A_A1, {8'hC3, a1}); m_a1 = a1;
    bus_wr(A_A2, {8'h3C, a2}); m_a2 = a2;
  endtask

  task automatic start();
    saddress = A_ST; sdata_in = '0; swr = 1'b1;
    @(posedge clk); @(negedge clk);
    if (m_busy) begin
      m_err = 1'b1;
    end else begin
      t0 = cyc;
      s_a1 = m_a1; s_a2 = m_a2;
      m_busy = 1'b1; m_err = 1'b0; m_done = 1'b0;
    end
    swr = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_done(input string tag);
    logic [63:0] prod;
    int n;
    n = 0;
    while (gpio_out == m_cnt && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 32'(cyc - t0), 32'd26);
    chk({tag, "_cnt"}, gpio_out, m_cnt + 32'd1);
    prod    = 64'(s_a1) * 64'(s_a2);
    m_w     = prod[31:0];
    m_valid = (prod[63:32] == 32'd0);
    m_l     = 32'($countones(m_w));
    m_done  = 1'b1;
    m_busy  = 1'b0;
    m_cnt   = m_cnt + 32'd1;
  endtask

  task automatic chk_result(input string tag);
    bus_rd(A_ST, rd); chk({tag, "_st"}, rd, m_status());
    bus_rd(A_W, rd);  chk({tag, "_w"}, rd, m_rd_w());
    bus_rd(A_L, rd);  chk({tag, "_l"}, rd, m_rd_l());
  endtask

  function automatic logic [23:0] pick();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 24'h0;
    if (r == 1) return 24'hFFFFFF;
    return 24'($urandom);
  endfunction

  initial begin
    logic [23:0] a1, a2;
    int n8;
    logic [31:0] p8;
    model_reset();
    gpio_in = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    chk("rst_sdata_out", sdata_out, 32'd0);
    chk("rst_gpio_out", gpio_out, 32'd0);
    chk("rst_insp", gpio_in_s_insp, 32'd0);
    n_reset = 1'b1;
    @(negedge clk);
    bus_rd(A_ST, rd); chk("rst_status", rd, 32'h3);
    bus_rd(A_NX, rd); chk("rst_unmapped", rd, 32'd0);
    bus_rd(A_A1, rd); chk("rst_a1", rd, 32'd0);
    bus_rd(A_A2, rd); chk("rst_a2", rd, 32'd0);
    bus_rd(A_W, rd);  chk("rst_w", rd, 32'd0);
    bus_rd(A_L, rd);  chk("rst_l", rd, 32'd0);
    bus_rd(A_GP, rd); chk("rst_gpin", rd, 32'd0);

    // basic 3 x 5
    wr_ops(24'd3, 24'd5);
    start();
    bus_rd(A_ST, rd); chk("basic_busy", rd, 32'h5);
    wait_done("basic");
    bus_rd(A_ST, rd); chk("basic_st", rd, 32'hB);
    bus_rd(A_W, rd);  chk("basic_w", rd, 32'd15);
    bus_rd(A_L, rd);  chk("basic_l", rd, 32'd4);
    chk("basic_gout", gpio_out, 32'd1);

    // overflow, then a start on the first cycle back in idle
    wr_ops(24'hFFFFFF, 24'hFFFFFF);
    start();
    wait_done("ovf");
    start();
    bus_rd(A_ST, rd); chk("b2b_busy", rd, 32'h4);
    wait_done("b2b");
    bus_rd(A_ST, rd); chk("ovf_st", rd, 32'hA);
    bus_rd(A_W, rd);  chk("ovf_w", rd, 32'hFE000001);
    bus_rd(A_L, rd);  chk("ovf_l", rd, 32'd8);

    // randomised operations with optional rejected start and operand rewrite
    for (int it = 0; it < 30; it++) begin
      a1 = pick();
      a2 = pick();
      wr_ops(a1, a2);
      bus_rd(A_A1, rd); chk("rnd_a1", rd, {8'd0, m_a1});
      bus_rd(A_A2, rd); chk("rnd_a2", rd, {8'd0, m_a2});
      start();
      bus_rd(A_ST, rd); chk("rnd_busy", rd, m_status());
      bus_rd(A_W, rd);  chk("rnd_w_busy", rd, 32'd0);
      if ($urandom_range(0, 1) == 1) begin
        start();
        bus_rd(A_ST, rd); chk("rnd_rej_st", rd, m_status());
      end
      if ($urandom_range(0, 1) == 1) begin
        bus_wr(A_A1, $urandom);
        m_a1 = sdata_in[23:0];
      end
      wait_done("rnd");
      chk_result("rnd");
    end

    // next accepted start clears a sticky err
    start();
    bus_rd(A_ST, rd); chk("clr_err_busy", rd, m_status());
    wait_done("clr_err");
    chk_result("clr_err");

    // reset in the middle of an operation
    wr_ops(24'd7, 24'd9);
    bus_rd(A_A1, rd);
    start();
    repeat (8) @(negedge clk);
    n_reset = 1'b0;
    #1;
    chk("mid_rst_sdata", sdata_out, 32'd0);
    chk("mid_rst_gout", gpio_out, 32'd0);
    chk("mid_rst_insp", gpio_in_s_insp, 32'd0);
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    bus_rd(A_ST, rd); chk("mid_rst_st", rd, 32'h3);
    bus_rd(A_A1, rd); chk("mid_rst_a1", rd, 32'd0);
    bus_rd(A_W, rd);  chk("mid_rst_w", rd, 32'd0);
    wr_ops(24'd7, 24'd9);
    start();
    wait_done("fresh");
    bus_rd(A_W, rd); chk("fresh_w", rd, 32'd63);
    bus_rd(A_L, rd); chk("fresh_l", rd, 32'd6);

    // gpio capture on the latch rise only
    gpio_in = 32'hA5A5_0F0F;
    gpio_latch = 1'b1;
    @(negedge clk);
    chk("gp_insp", gpio_in_s_insp, 32'hA5A5_0F0F);
    gpio_in = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("gp_hold", gpio_in_s_insp, 32'hA5A5_0F0F);
    bus_rd(A_GP, rd); chk("gp_read", rd, 32'hA5A5_0F0F);
    gpio_latch = 1'b0;
    @(negedge clk);
    gpio_latch = 1'b1;
    @(negedge clk);
    chk("gp_relatch", gpio_in_s_insp, 32'h1234_5678);
    gpio_latch = 1'b0;

    // AW=8, RW=16 instance: 0xFF x 0xFF
    wr_ops(24'hFF, 24'hFF);
    p8 = gout8;
    start();
    n8 = 0;
    while (gout8 == p8 && n8 < 100) begin
      @(negedge clk);
      n8++;
    end
    chk("aw8_lat", 32'(cyc - t0), 32'd10);
    chk("aw8_cnt", gout8, p8 + 32'd1);
    wait_done("aw24_ff");
    bus_rd(A_W, rd);
    chk("aw8_w", rd8, 32'hFE01);
    chk("aw24_ff_w", rd, m_rd_w());
    bus_rd(A_ST, rd);
    chk("aw8_st", rd8, 32'hB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
